// File: rtl/sincos_scheduler_if.sv
// Request, response and sine-lookup signals of the sin/cos scheduler.
// The master side owns the requesters, the consumer and the lookup table; the slave side is the scheduler.
interface sincos_scheduler_if #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4 * ROM_DEPTH)
);
    logic                   req0_valid;
    logic [ADDRW-1:0]       req0_angle;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [ADDRW-1:0]       req1_angle;
    logic                   req1_ready;
    logic [ADDRW-1:0]       lut_id;
    logic [2*ROM_WIDTH-1:0] lut_data;
    logic                   rsp_valid;
    logic                   rsp_src;
    logic [2*ROM_WIDTH-1:0] rsp_sin;
    logic [2*ROM_WIDTH-1:0] rsp_cos;
    logic                   rsp_ready;

    modport master (
        output req0_valid, req0_angle, req1_valid, req1_angle, lut_data, rsp_ready,
        input  req0_ready, req1_ready, lut_id, rsp_valid, rsp_src, rsp_sin, rsp_cos
    );

    modport slave (
        input  req0_valid, req0_angle, req1_valid, req1_angle, lut_data, rsp_ready,
        output req0_ready, req1_ready, lut_id, rsp_valid, rsp_src, rsp_sin, rsp_cos
    );
endinterface

// File: rtl/sincos_scheduler.sv
// Round-robin scheduler sharing one combinational sine lookup between two requesters;
// each grant performs a sin lookup at theta, then a cos lookup at theta + quarter turn.
module sincos_scheduler #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4 * ROM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    sincos_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SIN, COS, DONE} state_t;

    localparam logic [ADDRW-1:0] QUARTER = ADDRW'(ROM_DEPTH);

    state_t                 state_reg, state_next;
    logic [ADDRW-1:0]       angle_reg;
    logic                   last_grant_reg;
    logic                   src_reg;
    logic [2*ROM_WIDTH-1:0] sin_reg;
    logic [2*ROM_WIDTH-1:0] cos_reg;
    logic                   grant0, grant1;
    logic [ADDRW-1:0]       lut_id_next;

    always_comb begin
        state_next  = state_reg;
        grant0      = 1'b0;
        grant1      = 1'b0;
        lut_id_next = '0;
        case (state_reg)
            IDLE: begin
                // On a tie the requester that did not win last time gets the port.
                if (bus.req0_valid && bus.req1_valid) begin
                    grant0 = last_grant_reg;
                    grant1 = !last_grant_reg;
                end else begin
                    grant0 = bus.req0_valid;
                    grant1 = bus.req1_valid;
                end
                if (grant0 || grant1)
                    state_next = SIN;
            end
            SIN: begin
                lut_id_next = angle_reg;
                state_next  = COS;
            end
            COS: begin
                // Carry out of the add is dropped, giving the wrap around the full circle.
                lut_id_next = angle_reg + QUARTER;
                state_next  = DONE;
            end
            DONE: begin
                if (bus.rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            angle_reg      <= '0;
            last_grant_reg <= 1'b1;
            src_reg        <= 1'b0;
            sin_reg        <= '0;
            cos_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant0 || grant1) begin
                        angle_reg      <= grant1 ? bus.req1_angle : bus.req0_angle;
                        src_reg        <= grant1;
                        last_grant_reg <= grant1;
                    end
                end
                SIN:     sin_reg <= bus.lut_data;
                COS:     cos_reg <= bus.lut_data;
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.lut_id     = lut_id_next;
    assign bus.rsp_valid  = (state_reg == DONE);
    assign bus.rsp_src    = src_reg;
    assign bus.rsp_sin    = sin_reg;
    assign bus.rsp_cos    = cos_reg;
endmodule

// File: tb/tb_sincos_scheduler.sv
// Directed bench for sincos_scheduler: vector table of single requests plus
// hand-written reset, fairness, back-pressure and angle-change sequences.
module tb_sincos_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   sine_tab [256];

    always #5 clk = ~clk;

    sincos_scheduler_if #(.ROM_DEPTH(64), .ROM_WIDTH(8), .ADDRW(8)) bus ();

    sincos_scheduler #(.ROM_DEPTH(64), .ROM_WIDTH(8), .ADDRW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Full-circle sine lookup, 1.0 = 256.
    assign bus.lut_data = 16'(sine_tab[bus.lut_id]);

    typedef struct {
        logic        src;
        logic [7:0]  angle;
        logic [15:0] sin_e;
        logic [15:0] cos_e;
        logic [7:0]  cos_id;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic src, input logic valid, input logic [7:0] angle);
        if (src) begin
            bus.req1_valid = valid;
            bus.req1_angle = angle;
        end else begin
            bus.req0_valid = valid;
            bus.req0_angle = angle;
        end
    endtask

    // One request from idle; the angle input is scrambled right after the handshake.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_req(v.src, 1'b1, v.angle);
        #1;
        chk("req_ready", {bus.req1_ready, bus.req0_ready}, v.src ? 32'd2 : 32'd1);
        @(negedge clk);
        set_req(v.src, 1'b0, 8'd100);
        #1;
        chk("sin_id", bus.lut_id, v.angle);
        chk("busy_valid", bus.rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("cos_id", bus.lut_id, v.cos_id);
        @(negedge clk);
        #1;
        chk("rsp_valid_t3", bus.rsp_valid, 1);
        chk("rsp_src", bus.rsp_src, v.src);
        chk("rsp_sin", bus.rsp_sin, v.sin_e);
        chk("rsp_cos", bus.rsp_cos, v.cos_e);
        chk("done_id", bus.lut_id, 0);
        $display("vec src=%0d angle=%0d sin=%h cos=%h", v.src, v.angle, bus.rsp_sin, bus.rsp_cos);
        @(negedge clk);
        #1;
        chk("rsp_drop", bus.rsp_valid, 0);
    endtask

    initial begin
        int got;
        for (int k = 0; k < 256; k++)
            sine_tab[k] = $rtoi($floor(256.0 * $sin(2.0 * 3.14159265358979 * k / 256.0) + 0.5));

        vecs[0] = '{1'b0, 8'd0,   16'h0000, 16'h0100, 8'd64};
        vecs[1] = '{1'b1, 8'd64,  16'h0100, 16'h0000, 8'd128};
        vecs[2] = '{1'b0, 8'd192, 16'hFF00, 16'h0000, 8'd0};
        vecs[3] = '{1'b1, 8'd128, 16'h0000, 16'hFF00, 8'd192};
        vecs[4] = '{1'b0, 8'd32,  16'h00B5, 16'h00B5, 8'd96};
        vecs[5] = '{1'b1, 8'd96,  16'h00B5, 16'hFF4B, 8'd160};
        vecs[6] = '{1'b0, 8'd224, 16'hFF4B, 16'h00B5, 8'd32};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_angle = '0;
        bus.req1_valid = 1'b0; bus.req1_angle = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_lut_id", bus.lut_id, 0);
        chk("rst_sin", bus.rsp_sin, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted during COS discards the request
        @(negedge clk);
        set_req(1'b0, 1'b1, 8'd5);
        @(negedge clk);
        set_req(1'b0, 1'b0, 8'd5);
        @(negedge clk);
        #1;
        chk("midrst_cos_id", bus.lut_id, 69);
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.rsp_valid, 0);
        chk("midrst_id", bus.lut_id, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_rsp", bus.rsp_valid, 0);
        end
        $display("mid-operation reset sequence complete");

        // Table-driven single requests (also covers angle change after handshake)
        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // Continuous dual requests from reset: grants alternate 0,1,...
        @(negedge clk);
        rst = 1'b1;
        set_req(1'b0, 1'b1, 8'd32);
        set_req(1'b1, 1'b1, 8'd96);
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) begin
                chk("dual_src", bus.rsp_src, got[0]);
                chk("dual_sin", bus.rsp_sin, 16'h00B5);
                chk("dual_cos", bus.rsp_cos, got[0] ? 16'hFF4B : 16'h00B5);
                $display("dual result %0d src=%0d sin=%h cos=%h", got, bus.rsp_src, bus.rsp_sin, bus.rsp_cos);
                got++;
            end
        end
        chk("dual_count", got, 8);
        set_req(1'b0, 1'b0, 8'd0);
        set_req(1'b1, 1'b0, 8'd0);
        repeat (2) @(negedge clk);

        // Back-pressure in DONE with a pending request that must wait
        bus.rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 8'd64);
        @(negedge clk);
        set_req(1'b1, 1'b0, 8'd0);
        set_req(1'b0, 1'b1, 8'd128);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_src", bus.rsp_src, 1);
            chk("hold_sin", bus.rsp_sin, 16'h0100);
            chk("hold_cos", bus.rsp_cos, 16'h0000);
            chk("hold_ready", {bus.req1_ready, bus.req0_ready}, 0);
            @(negedge clk);
        end
        $display("stall of 10 cycles complete");
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release_drop", bus.rsp_valid, 0);
        chk("release_accept", bus.req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 8'd0);
        #1;
        chk("after_sin_id", bus.lut_id, 128);
        repeat (2) @(negedge clk);
        #1;
        chk("after_valid", bus.rsp_valid, 1);
        chk("after_src", bus.rsp_src, 0);
        chk("after_cos", bus.rsp_cos, 16'hFF00);
        $display("post-stall result src=%0d sin=%h cos=%h", bus.rsp_src, bus.rsp_sin, bus.rsp_cos);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
